// File: rtl/fetch_pkg.sv
// Shared types and default sizing for the instruction-fetch sequencer.
package fetch_pkg;

    localparam int unsigned DefDataWidth     = 32;
    localparam int unsigned DefAddrWidth     = 24;
    localparam int unsigned DefOpcodeSize    = 8;
    localparam int unsigned DefTimeoutCycles = 16;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StLoad,
        StHold,
        StError
    } fetch_state_e;

    // Counter must be able to hold TimeoutCycles itself.
    function automatic int unsigned wd_count_width(input int unsigned timeout_cycles);
        return $clog2(timeout_cycles + 1);
    endfunction

    localparam int unsigned DefWdCountWidth = wd_count_width(DefTimeoutCycles);

endpackage

// File: rtl/fetch_watchdog.sv
// Memory-handshake watchdog: counts REQ cycles without ack, flags the last allowed cycle.
module fetch_watchdog
    import fetch_pkg::*;
#(
    parameter int unsigned TimeoutCycles = DefTimeoutCycles
) (
    input  logic clock_i,
    input  logic reset_i,
    input  logic clear_i,
    input  logic count_en_i,
    output logic expire_o
);

    localparam int unsigned CntW = wd_count_width(TimeoutCycles);
    localparam logic [CntW-1:0] LastCnt = CntW'(TimeoutCycles - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (count_en_i) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    // Fires on the cycle whose increment would bring the count to TimeoutCycles.
    assign expire_o = count_en_i && !clear_i && (cnt_q == LastCnt);

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, runs the memory req/ack handshake,
// pulses the IR load enable and holds the instruction until the controller accepts it.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int unsigned DataWidth     = DefDataWidth,
    parameter int unsigned AddrWidth     = DefAddrWidth,
    parameter int unsigned OpcodeSize    = DefOpcodeSize,
    parameter int unsigned TimeoutCycles = DefTimeoutCycles
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic                 start_i,
    input  logic                 halt_i,
    input  logic                 mem_ack_i,
    input  logic                 instr_accept_i,
    input  logic                 branch_taken_i,
    input  logic [AddrWidth-1:0] branch_target_i,
    output logic                 mem_rd_req_o,
    output logic [AddrWidth-1:0] mem_addr_o,
    output logic                 ir_load_en_o,
    output logic                 instr_valid_o,
    output logic [AddrWidth-1:0] pc_out_o,
    output logic                 fetch_timeout_o,
    output logic                 busy_o
);

    if (TimeoutCycles < 2 || OpcodeSize > DataWidth) begin : g_bad_cfg
        $error("fetch_sequencer: TimeoutCycles must be >= 2 and OpcodeSize <= DataWidth");
    end

    fetch_state_e state_q, state_d;
    logic [AddrWidth-1:0] pc_q, pc_d;
    logic [AddrWidth-1:0] pc_out_q, pc_out_d;
    logic [AddrWidth-1:0] mem_addr_q, mem_addr_d;
    logic mem_rd_req_q, mem_rd_req_d;
    logic ir_load_en_q, ir_load_en_d;
    logic instr_valid_q, instr_valid_d;
    logic fetch_timeout_q, fetch_timeout_d;
    logic busy_q, busy_d;
    logic wd_expire;

    fetch_watchdog #(
        .TimeoutCycles(TimeoutCycles)
    ) u_watchdog (
        .clock_i   (clock_i),
        .reset_i   (reset_i),
        .clear_i   (state_q != StReq),
        .count_en_i(state_q == StReq && !mem_ack_i),
        .expire_o  (wd_expire)
    );

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        pc_out_d = pc_out_q;

        case (state_q)
            StIdle: begin
                if (!halt_i && start_i) state_d = StReq;
            end
            StReq: begin
                // Ack on the final allowed cycle still wins over the watchdog.
                if (mem_ack_i) begin
                    state_d  = StLoad;
                    pc_out_d = pc_q;
                    pc_d     = pc_q + AddrWidth'(1);
                end else if (wd_expire) begin
                    state_d = StError;
                end
            end
            StLoad: state_d = StHold;
            StHold: begin
                if (instr_accept_i) begin
                    if (branch_taken_i) pc_d = branch_target_i;
                    state_d = halt_i ? StIdle : StReq;
                end
            end
            StError: state_d = StError;
            default: state_d = StIdle;
        endcase

        // Outputs are registered images of the next state.
        mem_rd_req_d    = (state_d == StReq);
        mem_addr_d      = (state_d == StReq) ? pc_d : '0;
        ir_load_en_d    = (state_d == StLoad);
        instr_valid_d   = (state_d == StHold);
        fetch_timeout_d = (state_d == StError);
        busy_d          = (state_d != StIdle);
        if (state_d == StError) pc_out_d = '0;
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q         <= StIdle;
            pc_q            <= '0;
            pc_out_q        <= '0;
            mem_addr_q      <= '0;
            mem_rd_req_q    <= 1'b0;
            ir_load_en_q    <= 1'b0;
            instr_valid_q   <= 1'b0;
            fetch_timeout_q <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            pc_out_q        <= pc_out_d;
            mem_addr_q      <= mem_addr_d;
            mem_rd_req_q    <= mem_rd_req_d;
            ir_load_en_q    <= ir_load_en_d;
            instr_valid_q   <= instr_valid_d;
            fetch_timeout_q <= fetch_timeout_d;
            busy_q          <= busy_d;
        end
    end

    assign mem_rd_req_o    = mem_rd_req_q;
    assign mem_addr_o      = mem_addr_q;
    assign ir_load_en_o    = ir_load_en_q;
    assign instr_valid_o   = instr_valid_q;
    assign pc_out_o        = pc_out_q;
    assign fetch_timeout_o = fetch_timeout_q;
    assign busy_o          = busy_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scenario bench for fetch_sequencer; expected fetch addresses flow through a scoreboard queue.
module tb_fetch_sequencer;

    localparam int unsigned AW = 24;

    logic          clock, reset;
    logic          start, halt, mem_ack, instr_accept, branch_taken;
    logic [AW-1:0] branch_target;
    logic          mem_rd_req, ir_load_en, instr_valid, fetch_timeout, busy;
    logic [AW-1:0] mem_addr, pc_out;

    int            tests = 0;
    int            fails = 0;
    logic [AW-1:0] model_pc;
    logic [AW-1:0] exp_q[$];

    fetch_sequencer #(
        .DataWidth    (32),
        .AddrWidth    (AW),
        .OpcodeSize   (8),
        .TimeoutCycles(16)
    ) dut (
        .clock_i        (clock),
        .reset_i        (reset),
        .start_i        (start),
        .halt_i         (halt),
        .mem_ack_i      (mem_ack),
        .instr_accept_i (instr_accept),
        .branch_taken_i (branch_taken),
        .branch_target_i(branch_target),
        .mem_rd_req_o   (mem_rd_req),
        .mem_addr_o     (mem_addr),
        .ir_load_en_o   (ir_load_en),
        .instr_valid_o  (instr_valid),
        .pc_out_o       (pc_out),
        .fetch_timeout_o(fetch_timeout),
        .busy_o         (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish within time limit");
        $fatal(1, "time limit");
    end

    task automatic reset_dut();
        reset = 1'b1; start = 0; halt = 0; mem_ack = 0; instr_accept = 0;
        branch_taken = 0; branch_target = '0;
        @(negedge clock); @(negedge clock);
        reset = 1'b0;
        model_pc = '0;
        exp_q.delete();
    endtask

    task automatic start_fetch();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        tests++;
        if (mem_rd_req !== 1'b1) begin
            fails++; $display("FAIL start_latency: mem_rd_req=%b required 1", mem_rd_req);
        end
    endtask

    // Serves one request: ack after `delay` extra REQ cycles, checks load pulse and hold.
    task automatic do_fetch(input int delay);
        int waited = 0;
        logic [AW-1:0] exp;
        while (mem_rd_req !== 1'b1 && waited < 20) begin
            @(negedge clock); waited++;
        end
        tests++;
        if (mem_rd_req !== 1'b1) begin
            fails++; $display("FAIL req_wait: mem_rd_req=%b required 1", mem_rd_req);
        end
        tests++;
        if (mem_addr !== model_pc) begin
            fails++; $display("FAIL mem_addr: got %h required %h", mem_addr, model_pc);
        end
        exp_q.push_back(model_pc);
        repeat (delay) begin
            @(negedge clock);
            tests++;
            if (mem_rd_req !== 1'b1 || mem_addr !== exp_q[$]) begin
                fails++;
                $display("FAIL req_stable: req=%b addr=%h required 1/%h", mem_rd_req, mem_addr,
                         exp_q[$]);
            end
        end
        mem_ack = 1'b1;
        @(negedge clock);
        mem_ack = 1'b0;
        tests++;
        if ({ir_load_en, mem_rd_req, instr_valid} !== 3'b100) begin
            fails++;
            $display("FAIL load_pulse: load/req/valid=%b%b%b required 100", ir_load_en,
                     mem_rd_req, instr_valid);
        end
        exp = exp_q.pop_front();
        tests++;
        if (pc_out !== exp) begin
            fails++; $display("FAIL pc_out: got %h required %h", pc_out, exp);
        end
        model_pc = exp + AW'(1);
        @(negedge clock);
        tests++;
        if ({ir_load_en, instr_valid, busy, fetch_timeout} !== 4'b0110) begin
            fails++;
            $display("FAIL hold: load/valid/busy/tmo=%b%b%b%b required 0110", ir_load_en,
                     instr_valid, busy, fetch_timeout);
        end
    endtask

    task automatic accept(input logic br, input logic [AW-1:0] tgt, input logic hlt);
        instr_accept = 1'b1; branch_taken = br; branch_target = tgt; halt = hlt;
        @(negedge clock);
        instr_accept = 1'b0; branch_taken = 1'b0; halt = 1'b0;
        if (br) model_pc = tgt;
        tests++;
        if (instr_valid !== 1'b0) begin
            fails++; $display("FAIL accept_valid: instr_valid=%b required 0", instr_valid);
        end
        tests++;
        if (mem_rd_req !== !hlt || busy !== !hlt) begin
            fails++;
            $display("FAIL accept_next: req=%b busy=%b required %b", mem_rd_req, busy, !hlt);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 0; halt = 0; mem_ack = 0; instr_accept = 0;
        branch_taken = 0; branch_target = '0;
        #1;
        tests++;
        if ({mem_rd_req, mem_addr, ir_load_en, instr_valid, pc_out, fetch_timeout, busy} !== '0)
        begin
            fails++;
            $display("FAIL reset_outputs: req=%b addr=%h load=%b valid=%b pc=%h tmo=%b busy=%b required all 0",
                     mem_rd_req, mem_addr, ir_load_en, instr_valid, pc_out, fetch_timeout, busy);
        end
        reset_dut();
    endtask

    task automatic test_basic();
        start_fetch();
        do_fetch(3);
        accept(1'b0, '0, 1'b0);
        do_fetch(0);
    endtask

    task automatic test_branch();
        branch_taken = 1'b1; branch_target = 24'h123456;
        @(negedge clock);
        branch_taken = 1'b0;
        tests++;
        if (instr_valid !== 1'b1 || mem_rd_req !== 1'b0) begin
            fails++;
            $display("FAIL branch_ignored: valid=%b req=%b required 1/0", instr_valid, mem_rd_req);
        end
        accept(1'b1, 24'h00ABCD, 1'b0);
        do_fetch(0);
        accept(1'b0, '0, 1'b0);
        do_fetch(2);
    endtask

    task automatic test_wrap();
        accept(1'b1, 24'hFFFFFF, 1'b0);
        do_fetch(1);
        accept(1'b0, '0, 1'b0);
        do_fetch(0);
    endtask

    task automatic test_timeout();
        reset_dut();
        start_fetch();
        do_fetch(15);
        accept(1'b0, '0, 1'b0);
        repeat (15) begin
            @(negedge clock);
            tests++;
            if (mem_rd_req !== 1'b1 || fetch_timeout !== 1'b0) begin
                fails++;
                $display("FAIL pre_timeout: req=%b tmo=%b required 1/0", mem_rd_req, fetch_timeout);
            end
        end
        @(negedge clock);
        tests++;
        if ({mem_rd_req, fetch_timeout, busy, ir_load_en, instr_valid} !== 5'b01100 ||
            mem_addr !== '0 || pc_out !== '0) begin
            fails++;
            $display("FAIL timeout_error: req/tmo/busy/load/valid=%b%b%b%b%b addr=%h pc=%h required 01100/0/0",
                     mem_rd_req, fetch_timeout, busy, ir_load_en, instr_valid, mem_addr, pc_out);
        end
        start = 1'b1; mem_ack = 1'b1; instr_accept = 1'b1;
        repeat (3) @(negedge clock);
        start = 1'b0; mem_ack = 1'b0; instr_accept = 1'b0;
        @(negedge clock);
        tests++;
        if ({mem_rd_req, fetch_timeout, busy, ir_load_en, instr_valid} !== 5'b01100) begin
            fails++;
            $display("FAIL error_sticky: req/tmo/busy/load/valid=%b%b%b%b%b required 01100",
                     mem_rd_req, fetch_timeout, busy, ir_load_en, instr_valid);
        end
        reset_dut();
        tests++;
        if (fetch_timeout !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL error_reset: tmo=%b busy=%b required 0/0", fetch_timeout, busy);
        end
    endtask

    task automatic test_halt();
        reset_dut();
        start_fetch();
        halt = 1'b1;
        do_fetch(2);
        accept(1'b0, '0, 1'b1);
        repeat (3) begin
            @(negedge clock);
            tests++;
            if (mem_rd_req !== 1'b0 || busy !== 1'b0) begin
                fails++;
                $display("FAIL halt_idle: req=%b busy=%b required 0/0", mem_rd_req, busy);
            end
        end
        start = 1'b1; halt = 1'b1;
        repeat (2) @(negedge clock);
        start = 1'b0; halt = 1'b0;
        tests++;
        if (mem_rd_req !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL halt_priority: req=%b busy=%b required 0/0", mem_rd_req, busy);
        end
        start_fetch();
        do_fetch(0);
    endtask

    task automatic test_async_reset();
        reset_dut();
        start_fetch();
        mem_ack = 1'b1;
        @(negedge clock);
        mem_ack = 1'b0;
        tests++;
        if (ir_load_en !== 1'b1) begin
            fails++; $display("FAIL in_load: ir_load_en=%b required 1", ir_load_en);
        end
        #2 reset = 1'b1;
        #1;
        tests++;
        if ({mem_rd_req, mem_addr, ir_load_en, instr_valid, pc_out, fetch_timeout, busy} !== '0)
        begin
            fails++;
            $display("FAIL reset_in_load: load=%b valid=%b busy=%b pc=%h required all 0",
                     ir_load_en, instr_valid, busy, pc_out);
        end
        @(negedge clock);
        reset = 1'b0; model_pc = '0; exp_q.delete();
        start_fetch();
        do_fetch(0);
        accept(1'b0, '0, 1'b0);
        do_fetch(0);
        #2 reset = 1'b1;
        #1;
        tests++;
        if ({mem_rd_req, mem_addr, ir_load_en, instr_valid, pc_out, fetch_timeout, busy} !== '0)
        begin
            fails++;
            $display("FAIL reset_in_hold: valid=%b busy=%b pc=%h required all 0",
                     instr_valid, busy, pc_out);
        end
        @(negedge clock);
        reset = 1'b0; model_pc = '0; exp_q.delete();
        start_fetch();
        do_fetch(1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_branch();
        test_wrap();
        test_timeout();
        test_halt();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
